mem_core: RTL
=============

# mem_core

Single-port synchronous memory array (16 x 32 by default) that consumes the bus driven through the memory test interface: `write_en`, `read_en`, `address` and `data_in` in, registered `data_out` plus a one-cycle `valid_out` strobe back. After reset an internal sweep clears every location before requests are accepted; `ready` reports when that sweep is done. The block is the design-under-test for the memory UVM environment.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH
- clk  input  1  single clock; all logic on posedge
- reset_n  input  1  reset, asynchronous assert, active-low
- write_en  input  1  write request, sampled on posedge
- read_en  input  1  read request, sampled on posedge
- address  input  ADDR_WIDTH  location for read and/or write
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  read data, registered
- valid_out  output  1  one-cycle strobe: data_out holds fresh read data
- ready  output  1  high once init sweep complete; requests honoured only when high
- parity_err  output  1  present only with MEM_PARITY_EN (see Configuration)

## Operation
- Reset is asynchronous, active-low: one clock `clk`, reset `reset_n`.
- FSM states: INIT, RUN. Reset forces INIT, sweep counter = 0.
- INIT: each cycle writes 0 to location `sweep_cnt`, increments it; after writing location depth-1 go to RUN. ready=0; write_en/read_en ignored (dropped, no valid_out).
- RUN: ready=1, stays in RUN until reset.
- Write: write_en=1 at edge stores data_in at address.
- Read: read_en=1 at edge loads mem[address] into data_out, valid_out=1 for that cycle.
- Simultaneous write_en and read_en, same address: write-first; data_out = data_in of that cycle.
- read_en=0: valid_out=0, data_out holds last read value.
- Address wraps naturally; no out-of-range case (depth = 2**ADDR_WIDTH).
- Reset mid-operation (any state): outputs immediately to reset values, FSM to INIT, full sweep restarts; contents treated as cleared only after new sweep.
- Reset values: data_out=0, valid_out=0, ready=0, parity_err=0.

## Timing
- Read latency 1: read_en at edge N -> data_out/valid_out valid after edge N, through edge N+1.
- Back-to-back reads every cycle supported; valid_out stays high each cycle.
- Write visible to a read at the same edge (write-first) and any later edge.
- Init: ready rises after edge depth (16) following reset release; first request honoured at edge 17.
- ready and valid_out are register outputs; no combinational path input->output.

## Configuration
- MEM_PARITY_EN defined: each word stores an extra even-parity bit computed from data_in on write (0 during sweep, matching zero data). On read, parity_err=1 in the same cycle as valid_out if stored parity != ^stored data; else 0. parity_err=0 whenever valid_out=0. data_out still returns stored data.
- MEM_PARITY_EN undefined: no parity bit storage, no parity_err port; all other behaviour identical.

## Test plan
- Reset release, read_en=1 address 3 on cycles 1-16 -> valid_out stays 0, ready rises after edge 16; read addr 3 at edge 17 -> data_out=0x00000000, valid_out=1.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle -> data_out=0xDEADBEEF, valid_out=1 one cycle, then 0 with data_out held.
- Same-edge write 0x12345678 + read addr 9 -> data_out=0x12345678 after that edge.
- Write addr i = i*0x01010101 for all 16, back-to-back reads 0..15 -> 16 consecutive valid_out cycles, correct values, addr 15 then 0 wraps cleanly.
- Write addr 2 = 0xA5A5A5A5, assert reset_n=0 mid-read -> outputs 0 immediately; after re-sweep read addr 2 -> 0x00000000.
- MEM_PARITY_EN: write addr 7 = 0x1, force-flip stored bit 0, read addr 7 -> valid_out=1, parity_err=1; read clean addr 6 -> parity_err=0.

Source files
------------

// File: rtl/mem_core.sv
// mem_core: single-port synchronous memory, DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits.
// After reset an internal sweep writes zero to every location, one per clock. Requests
// are honoured only once that sweep is done, which is when `ready` goes high.
//
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word. The bit
// is checked on every read and reported on parity_err.
//
// Ports:
//   clk         clock, all logic on posedge
//   reset_n     asynchronous assert, active-low reset
//   write_en    write request (honoured only when ready)
//   read_en     read request (honoured only when ready)
//   address     location for the read and/or write
//   data_in     write data
//   data_out    registered read data, holds its value between reads
//   valid_out   one-cycle strobe, high when data_out carries fresh read data
//   ready       high once the init sweep is complete
//   parity_err  (MEM_PARITY_EN only) stored parity mismatch, qualified by valid_out
module mem_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  ready
`ifdef MEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    valid_q;
  logic                    ready_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Shared write port: the sweep owns it during INIT, and user writes are
  // dropped there.
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   data_out_d;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data_in;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt_q;
      mem_wdata = '0;
    end else if (write_en) begin
      mem_we    = 1'b1;
    end
  end

  // Write-first: a read at the same edge as a write returns the new data.
  assign data_out_d = write_en ? data_in : mem_q[address];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic parity_err_q;
  logic parity_err_d;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem_q[mem_waddr] <= ^mem_wdata;
    end
  end

  // A same-edge write bypasses the array, so its parity is consistent by construction.
  assign parity_err_d = write_en ? 1'b0 : (par_mem_q[address] != ^mem_q[address]);
  assign parity_err   = parity_err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
`ifdef MEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef MEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        INIT: begin
          sweep_cnt_q <= sweep_cnt_q + ADDR_WIDTH'(1);
          if (sweep_cnt_q == LAST_ADDR) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
          if (read_en) begin
            data_out_q <= data_out_d;
            valid_q    <= 1'b1;
`ifdef MEM_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
          end
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign ready     = ready_q;

endmodule
